// File: rtl/lock_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : lock_access_controller
// Brief    : 4-digit keypad lock with consecutive-failure lockout, entry
//            timeout and registered status outputs. Defining LOCK_PROG_EN
//            enables reprogramming of the code from the OPEN state.
// Revision : 1.0 - initial release
// ============================================================================
module lock_access_controller #(
    parameter logic [7:0] CODE_DEFAULT   = 8'h2D,
    parameter int         MAX_FAIL       = 3,
    parameter int         LOCKOUT_CYCLES = 16,
    parameter int         OPEN_CYCLES    = 8,
    parameter int         TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       prog_req,
    output logic       unlock,
    output logic       locked_out,
    output logic       entry_busy,
    output logic       prog_active,
    output logic [1:0] fail_cnt
);

    localparam int C_TMAX_OL = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int C_TMAX    = (C_TMAX_OL > TIMEOUT_CYCLES) ? C_TMAX_OL : TIMEOUT_CYCLES;
    localparam int C_TW      = $clog2(C_TMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_t;

    state_t          r_state, w_state_n;
    logic [3:0]      r_btn_d;
    logic [1:0]      r_idx, w_idx_n;
    logic            r_mismatch, w_mismatch_n;
    logic [C_TW-1:0] r_timer, w_timer_n;
    logic [1:0]      r_fail, w_fail_n;
    logic [7:0]      w_code;

    logic [3:0]      w_evt;
    logic            w_any;
    logic            w_valid;
    logic [1:0]      w_digit;
    logic [1:0]      w_code_digit;
    logic            w_key_bad;
    logic            w_miss_all;
    logic [1:0]      w_fail_inc;
    logic            w_timer_exp;

`ifdef LOCK_PROG_EN
    logic [7:0]      r_code, w_code_n;
    logic [5:0]      r_new_code, w_new_code_n;

    assign w_code = r_code;
`else
    logic            w_unused_prog_req;

    assign w_code            = CODE_DEFAULT;
    assign w_unused_prog_req = prog_req;
`endif

    // Rising-edge detection: a held button yields exactly one key event.
    assign w_evt       = btn & ~r_btn_d;
    assign w_any       = |w_evt;
    assign w_valid     = w_any && ((w_evt & (w_evt - 4'd1)) == 4'd0);
    assign w_digit     = {w_evt[3] | w_evt[2], w_evt[3] | w_evt[1]};
    assign w_key_bad   = !w_valid || (w_digit != w_code_digit);
    assign w_miss_all  = r_mismatch | w_key_bad;
    assign w_fail_inc  = r_fail + 2'd1;
    assign w_timer_exp = (r_timer == C_TW'(1));
    assign fail_cnt    = r_fail;

    always_comb begin
        case (r_idx)
            2'd0:    w_code_digit = w_code[7:6];
            2'd1:    w_code_digit = w_code[5:4];
            2'd2:    w_code_digit = w_code[3:2];
            default: w_code_digit = w_code[1:0];
        endcase
    end

    always_comb begin
        w_state_n    = r_state;
        w_idx_n      = r_idx;
        w_mismatch_n = r_mismatch;
        w_timer_n    = r_timer;
        w_fail_n     = r_fail;
`ifdef LOCK_PROG_EN
        w_code_n     = r_code;
        w_new_code_n = r_new_code;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_n    = ST_ENTRY;
                    w_idx_n      = 2'd1;
                    w_mismatch_n = w_key_bad;
                    w_timer_n    = C_TW'(TIMEOUT_CYCLES);
                end
            end
            ST_ENTRY: begin
                if (w_any) begin
                    if (r_idx == 2'd3) begin
                        w_idx_n      = 2'd0;
                        w_mismatch_n = 1'b0;
                        if (!w_miss_all) begin
                            w_state_n = ST_OPEN;
                            w_fail_n  = 2'd0;
                            w_timer_n = C_TW'(OPEN_CYCLES);
                        end else begin
                            w_fail_n = w_fail_inc;
                            if (w_fail_inc == 2'(MAX_FAIL)) begin
                                w_state_n = ST_LOCKOUT;
                                w_timer_n = C_TW'(LOCKOUT_CYCLES);
                            end else begin
                                w_state_n = ST_IDLE;
                                w_timer_n = '0;
                            end
                        end
                    end else begin
                        w_idx_n      = r_idx + 2'd1;
                        w_mismatch_n = w_miss_all;
                        w_timer_n    = C_TW'(TIMEOUT_CYCLES);
                    end
                end else if (w_timer_exp) begin
                    w_state_n    = ST_IDLE;
                    w_idx_n      = 2'd0;
                    w_mismatch_n = 1'b0;
                    w_timer_n    = '0;
                end else begin
                    w_timer_n = r_timer - C_TW'(1);
                end
            end
            ST_OPEN: begin
`ifdef LOCK_PROG_EN
                if (prog_req) begin
                    w_state_n = ST_PROG;
                    w_idx_n   = 2'd0;
                    w_timer_n = C_TW'(TIMEOUT_CYCLES);
                end else
`endif
                if (w_timer_exp) begin
                    w_state_n = ST_IDLE;
                    w_timer_n = '0;
                end else begin
                    w_timer_n = r_timer - C_TW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (w_timer_exp) begin
                    w_state_n = ST_IDLE;
                    w_fail_n  = 2'd0;
                    w_timer_n = '0;
                end else begin
                    w_timer_n = r_timer - C_TW'(1);
                end
            end
`ifdef LOCK_PROG_EN
            ST_PROG: begin
                if (w_any) begin
                    if (!w_valid) begin
                        w_state_n = ST_IDLE;
                        w_idx_n   = 2'd0;
                        w_timer_n = '0;
                    end else if (r_idx == 2'd3) begin
                        // New code only takes effect once all four digits are in.
                        w_code_n  = {r_new_code, w_digit};
                        w_state_n = ST_IDLE;
                        w_idx_n   = 2'd0;
                        w_timer_n = '0;
                    end else begin
                        w_new_code_n = {r_new_code[3:0], w_digit};
                        w_idx_n      = r_idx + 2'd1;
                        w_timer_n    = C_TW'(TIMEOUT_CYCLES);
                    end
                end else if (w_timer_exp) begin
                    w_state_n = ST_IDLE;
                    w_idx_n   = 2'd0;
                    w_timer_n = '0;
                end else begin
                    w_timer_n = r_timer - C_TW'(1);
                end
            end
`endif
            default: begin
                w_state_n    = ST_IDLE;
                w_idx_n      = 2'd0;
                w_mismatch_n = 1'b0;
                w_timer_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_btn_d    <= 4'd0;
            r_idx      <= 2'd0;
            r_mismatch <= 1'b0;
            r_timer    <= '0;
            r_fail     <= 2'd0;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
            entry_busy <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_btn_d    <= btn;
            r_idx      <= w_idx_n;
            r_mismatch <= w_mismatch_n;
            r_timer    <= w_timer_n;
            r_fail     <= w_fail_n;
            unlock     <= (w_state_n == ST_OPEN);
            locked_out <= (w_state_n == ST_LOCKOUT);
            entry_busy <= (w_state_n == ST_ENTRY) || (w_state_n == ST_PROG);
        end
    end

`ifdef LOCK_PROG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code      <= CODE_DEFAULT;
            r_new_code  <= 6'd0;
            prog_active <= 1'b0;
        end else begin
            r_code      <= w_code_n;
            r_new_code  <= w_new_code_n;
            prog_active <= (w_state_n == ST_PROG);
        end
    end
`else
    assign prog_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lock_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_access_controller
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_access_controller;

    localparam logic [7:0] CODE  = 8'h2D;
    localparam int         MAXF  = 3;
    localparam int         LOCKC = 16;
    localparam int         OPENC = 8;
    localparam int         TOC   = 32;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_OPEN  = 2;
    localparam int M_LOCK  = 3;
    localparam int M_PROG  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       prog_req;
    logic       unlock;
    logic       locked_out;
    logic       entry_busy;
    logic       prog_active;
    logic [1:0] fail_cnt;

    lock_access_controller #(
        .CODE_DEFAULT  (CODE),
        .MAX_FAIL      (MAXF),
        .LOCKOUT_CYCLES(LOCKC),
        .OPEN_CYCLES   (OPENC),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .locked_out (locked_out),
        .entry_busy (entry_busy),
        .prog_active(prog_active),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_unlock;
    int n_lock;

    // Reference model: digits typed so far, idle gap, cycles left in timed modes.
    int         m_mode;
    int         m_idle;
    int         m_remain;
    int         m_fails;
    int         m_keys[$];
    logic [7:0] m_code;
    logic [3:0] m_prev;

    typedef struct {
        logic [3:0] b;
        logic       p;
        logic       ul;
        logic       lo;
        logic       eb;
        logic       pa;
        logic [1:0] fc;
    } vec_t;

    vec_t tv[$];

    function automatic int code_digit(input logic [7:0] c, input int i);
        logic [7:0] s;
        s = (c >> (2 * (3 - i))) & 8'd3;
        return int'(s);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ul, input logic lo, input logic eb,
                            input logic pa, input logic [1:0] fc);
        check({tag, ".unlock"},      {7'd0, unlock},      {7'd0, ul});
        check({tag, ".locked_out"},  {7'd0, locked_out},  {7'd0, lo});
        check({tag, ".entry_busy"},  {7'd0, entry_busy},  {7'd0, eb});
        check({tag, ".prog_active"}, {7'd0, prog_active}, {7'd0, pa});
        check({tag, ".fail_cnt"},    {6'd0, fail_cnt},    {6'd0, fc});
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_idle   = 0;
        m_remain = 0;
        m_fails  = 0;
        m_keys.delete();
        m_code   = CODE;
        m_prev   = 4'd0;
    endtask

    task automatic model_tick(input logic [3:0] b, input logic p);
        logic [3:0] ev;
        int         d;
        bit         ok;
        ev     = b & ~m_prev;
        m_prev = b;
        d = 0;
        for (int k = 0; k < 4; k++) if (ev[k]) d = k;
        if ($countones(ev) != 1) d = 4;
        case (m_mode)
            M_IDLE: begin
                if (ev != 4'd0) begin
                    m_keys.delete();
                    m_keys.push_back(d);
                    m_idle = 0;
                    m_mode = M_ENTRY;
                end
            end
            M_ENTRY: begin
                if (ev != 4'd0) begin
                    m_keys.push_back(d);
                    m_idle = 0;
                    if (m_keys.size() == 4) begin
                        ok = 1'b1;
                        for (int i = 0; i < 4; i++) if (m_keys[i] != code_digit(m_code, i)) ok = 1'b0;
                        m_keys.delete();
                        if (ok) begin
                            m_mode = M_OPEN; m_remain = OPENC; m_fails = 0;
                        end else begin
                            m_fails++;
                            if (m_fails == MAXF) begin
                                m_mode = M_LOCK; m_remain = LOCKC;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TOC) begin
                        m_mode = M_IDLE;
                        m_keys.delete();
                    end
                end
            end
            M_OPEN: begin
`ifdef LOCK_PROG_EN
                if (p) begin
                    m_mode = M_PROG;
                    m_keys.delete();
                    m_idle = 0;
                end else
`endif
                begin
                    m_remain--;
                    if (m_remain == 0) m_mode = M_IDLE;
                end
            end
            M_LOCK: begin
                m_remain--;
                if (m_remain == 0) begin
                    m_mode  = M_IDLE;
                    m_fails = 0;
                end
            end
            M_PROG: begin
                if (ev != 4'd0) begin
                    if (d == 4) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_keys.push_back(d);
                        m_idle = 0;
                        if (m_keys.size() == 4) begin
                            m_code = 8'(m_keys[0] * 64 + m_keys[1] * 16 + m_keys[2] * 4 + m_keys[3]);
                            m_mode = M_IDLE;
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TOC) m_mode = M_IDLE;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic step(input logic [3:0] b, input logic p);
        logic [1:0] mf;
        @(negedge clk);
        btn      = b;
        prog_req = p;
        @(posedge clk);
        model_tick(b, p);
        #1;
        mf = m_fails[1:0];
        chk_outs("model", m_mode == M_OPEN, m_mode == M_LOCK,
                 (m_mode == M_ENTRY) || (m_mode == M_PROG), m_mode == M_PROG, mf);
        if (unlock === 1'b1) n_unlock++;
        if (locked_out === 1'b1) n_lock++;
    endtask

    task automatic press(input int d);
        step(4'(1 << d), 1'b0);
        step(4'd0, 1'b0);
    endtask

    task automatic press_code(input logic [7:0] c);
        for (int i = 0; i < 4; i++) press(code_digit(c, i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst      = 1'b1;
        btn      = 4'd0;
        prog_req = 1'b0;
        #1;
        chk_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_outs("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic tv_add(input logic [3:0] b, input logic ul, input logic lo,
                          input logic eb, input logic [1:0] fc);
        vec_t v;
        v.b = b; v.p = 1'b0; v.ul = ul; v.lo = lo; v.eb = eb; v.pa = 1'b0; v.fc = fc;
        tv.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         r;
        int         s;
        logic [3:0] b;
        logic       p;

        rst      = 1'b1;
        btn      = 4'd0;
        prog_req = 1'b0;
        model_reset();

        // Correct entry A,C,D,B with gaps: open for exactly 8 cycles.
        tv_add(4'h1, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h4, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h8, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h2, 1, 0, 0, 2'd0);
        for (int i = 0; i < 7; i++) tv_add(4'h0, 1, 0, 0, 2'd0);
        tv_add(4'h0, 0, 0, 0, 2'd0);
        // A+C together is an invalid digit; then a held A counts once.
        tv_add(4'h5, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h4, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h8, 0, 0, 1, 2'd0); tv_add(4'h0, 0, 0, 1, 2'd0);
        tv_add(4'h2, 0, 0, 0, 2'd1);
        for (int i = 0; i < 10; i++) tv_add(4'h1, 0, 0, 1, 2'd1);
        tv_add(4'h0, 0, 0, 1, 2'd1);
        tv_add(4'h4, 0, 0, 1, 2'd1); tv_add(4'h0, 0, 0, 1, 2'd1);
        tv_add(4'h8, 0, 0, 1, 2'd1); tv_add(4'h0, 0, 0, 1, 2'd1);
        tv_add(4'h2, 1, 0, 0, 2'd0);
        for (int i = 0; i < 7; i++) tv_add(4'h0, 1, 0, 0, 2'd0);
        tv_add(4'h0, 0, 0, 0, 2'd0);

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].b, tv[i].p);
            chk_outs($sformatf("tv%0d", i), tv[i].ul, tv[i].lo, tv[i].eb, tv[i].pa, tv[i].fc);
        end

        // Three wrong entries, lockout of 16 cycles ignoring a correct code.
        do_reset();
        n_lock   = 0;
        n_unlock = 0;
        press_code(8'h1B);
        check("fail_after_1", {6'd0, fail_cnt}, 8'd1);
        press_code(8'h1B);
        check("fail_after_2", {6'd0, fail_cnt}, 8'd2);
        press(0); press(1); press(2);
        step(4'h8, 1'b0);
        check("lockout_entered", {7'd0, locked_out}, 8'd1);
        check("fail_at_max", {6'd0, fail_cnt}, 8'd3);
        step(4'h0, 1'b0);
        press_code(CODE);
        check("lockout_ignores_code", {7'd0, unlock}, 8'd0);
        repeat (10) step(4'h0, 1'b0);
        check("lockout_len", 8'(n_lock), 8'd16);
        check("lockout_no_unlock", 8'(n_unlock), 8'd0);
        check("fail_cleared", {6'd0, fail_cnt}, 8'd0);

        // Entry timeout boundary at 31/32 idle cycles.
        do_reset();
        press(0); press(2);
        repeat (30) step(4'h0, 1'b0);
        check("idle31_busy", {7'd0, entry_busy}, 8'd1);
        step(4'h0, 1'b0);
        check("idle32_busy", {7'd0, entry_busy}, 8'd0);
        press(3); press(1);
        check("after_to_busy", {7'd0, entry_busy}, 8'd1);
        check("after_to_unlock", {7'd0, unlock}, 8'd0);
        check("after_to_fail", {6'd0, fail_cnt}, 8'd0);
        press(0); press(0);
        check("after_to_4th", {6'd0, fail_cnt}, 8'd1);

        // Key arriving on the would-be expiry cycle is accepted.
        do_reset();
        press(0);
        repeat (30) step(4'h0, 1'b0);
        step(4'h4, 1'b0);
        check("key_at_expiry_busy", {7'd0, entry_busy}, 8'd1);
        step(4'h0, 1'b0);
        press(3);
        step(4'h2, 1'b0);
        check("key_at_expiry_unlock", {7'd0, unlock}, 8'd1);
        repeat (10) step(4'h0, 1'b0);

        // Reset mid-entry, then a full correct entry.
        do_reset();
        press(0); press(2); press(3);
        check("mid_entry_busy", {7'd0, entry_busy}, 8'd1);
        do_reset();
        press(0); press(2); press(3);
        step(4'h2, 1'b0);
        check("post_rst_unlock", {7'd0, unlock}, 8'd1);
        repeat (10) step(4'h0, 1'b0);

`ifdef LOCK_PROG_EN
        do_reset();
        press_code(CODE);
        check("prog_open", {7'd0, unlock}, 8'd1);
        step(4'h0, 1'b1);
        check("prog_active", {7'd0, prog_active}, 8'd1);
        check("prog_unlock_drop", {7'd0, unlock}, 8'd0);
        press_code(8'h53);
        check("prog_done", {7'd0, prog_active}, 8'd0);
        press_code(8'h53);
        check("new_code_unlock", {7'd0, unlock}, 8'd1);
        repeat (10) step(4'h0, 1'b0);
        press_code(CODE);
        check("old_code_rejected", {6'd0, fail_cnt}, 8'd1);
        do_reset();
        press_code(CODE);
        check("rst_restores_code", {7'd0, unlock}, 8'd1);
        repeat (10) step(4'h0, 1'b0);
`endif

        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                do_reset();
            end else if (r < 12 && m_mode == M_IDLE) begin
                press_code(m_code);
            end else begin
                s = int'($urandom_range(0, 99));
                if (s < 55)      b = 4'd0;
                else if (s < 85) b = 4'(1 << $urandom_range(0, 3));
                else if (s < 92) b = 4'($urandom);
                else             b = btn;
                p = ($urandom_range(0, 15) == 0);
                step(b, p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
